// File: rtl/daddr_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | daddr_bank                                                               |
// | Bank of NUM_PTR data-address pointers updated by one op per cycle.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module daddr_bank #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 16,
  parameter int NUM_PTR       = 4,
  parameter int IMM_BITWIDTH  = 11,
  parameter int STRIDE        = 1,
  parameter int SAT_MODE      = 0,
  localparam int PSW   = (NUM_PTR > 1) ? $clog2(NUM_PTR) : 1,
  localparam int LANES = (ADDR_BITWIDTH + DATA_BITWIDTH - 1) / DATA_BITWIDTH,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  input  logic [2:0]               op_code,
  input  logic [PSW-1:0]           op_ptr,
  input  logic [LW-1:0]            op_lane,
  input  logic                     op_neg,
  input  logic [IMM_BITWIDTH-1:0]  op_imm,
  input  logic [DATA_BITWIDTH-1:0] data,
  input  logic [PSW-1:0]           rd_ptr,
  output logic [ADDR_BITWIDTH-1:0] data_addr,
  output logic [NUM_PTR-1:0]       ovf_flags
);

  localparam int       c_AW           = ADDR_BITWIDTH;
  localparam logic [2:0] c_OP_MOD      = 3'd1;
  localparam logic [2:0] c_OP_SET_IMM  = 3'd2;
  localparam logic [2:0] c_OP_SET_DATA = 3'd3;
  localparam logic [2:0] c_OP_INC      = 3'd4;
  localparam logic [2:0] c_OP_COPY     = 3'd5;
  localparam logic [2:0] c_OP_CLR      = 3'd6;

  logic [c_AW-1:0]          r_ptr [NUM_PTR];
  logic [NUM_PTR-1:0]       r_ovf;

  logic [c_AW-1:0]          w_cur;
  logic [c_AW-1:0]          w_src;
  logic                     w_ptr_ok;
  logic                     w_sub;
  logic [c_AW:0]            w_opnd;
  logic [c_AW:0]            w_sum;
  logic                     w_carry;
  logic [c_AW-1:0]          w_arith;
  logic [DATA_BITWIDTH-1:0] w_lane_val;
  logic [c_AW-1:0]          w_set;
  logic [c_AW-1:0]          w_next;
  logic                     w_we;
  logic                     w_set_ovf;
  logic                     w_clr_ovf;

  // Out-of-range indices (non-power-of-2 NUM_PTR) match no register.
  always_comb begin
    w_cur    = '0;
    w_src    = '0;
    w_ptr_ok = 1'b0;
    for (int i = 0; i < NUM_PTR; i++) begin
      if (op_ptr == PSW'(i)) begin
        w_cur    = r_ptr[i];
        w_ptr_ok = 1'b1;
      end
      if (rd_ptr == PSW'(i)) begin
        w_src = r_ptr[i];
      end
    end
  end

  // One extra bit captures carry on add and borrow on subtract alike.
  always_comb begin
    w_sub   = (op_code == c_OP_MOD) && op_neg;
    w_opnd  = (op_code == c_OP_INC) ? (c_AW+1)'(STRIDE) : (c_AW+1)'(op_imm);
    w_sum   = w_sub ? ({1'b0, w_cur} - w_opnd) : ({1'b0, w_cur} + w_opnd);
    w_carry = w_sum[c_AW];
    if (w_carry && (SAT_MODE != 0)) begin
      w_arith = w_sub ? '0 : '1;
    end else begin
      w_arith = w_sum[c_AW-1:0];
    end
  end

  assign w_lane_val = (op_code == c_OP_SET_IMM) ? op_imm[DATA_BITWIDTH-1:0] : data;

  // Top lane may be narrower than DATA_BITWIDTH; excess lane bits are dropped.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int LO = l * DATA_BITWIDTH;
    localparam int HI = (LO + DATA_BITWIDTH > c_AW) ? c_AW : (LO + DATA_BITWIDTH);
    assign w_set[HI-1:LO] = (op_lane == LW'(l)) ? w_lane_val[HI-LO-1:0] : w_cur[HI-1:LO];
  end

  always_comb begin
    w_next    = w_cur;
    w_we      = 1'b0;
    w_set_ovf = 1'b0;
    w_clr_ovf = 1'b0;
    case (op_code)
      c_OP_MOD, c_OP_INC: begin
        w_next    = w_arith;
        w_we      = 1'b1;
        w_set_ovf = w_carry;
      end
      c_OP_SET_IMM, c_OP_SET_DATA: begin
        w_next = w_set;
        w_we   = 1'b1;
      end
      c_OP_COPY: begin
        w_next = w_src;
        w_we   = 1'b1;
      end
      c_OP_CLR: begin
        w_next    = '0;
        w_we      = 1'b1;
        w_clr_ovf = 1'b1;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
    w_we = w_we && op_valid && w_ptr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PTR; i++) begin
        r_ptr[i] <= '0;
      end
      r_ovf <= '0;
    end else if (w_we) begin
      for (int i = 0; i < NUM_PTR; i++) begin
        if (op_ptr == PSW'(i)) begin
          r_ptr[i] <= w_next;
          if (w_clr_ovf) begin
            r_ovf[i] <= 1'b0;
          end else if (w_set_ovf) begin
            r_ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign data_addr = w_src;
  assign ovf_flags = r_ovf;

endmodule
`default_nettype wire
